// File: rtl/l2_slave_rr_arbiter_pkg.sv
// Shared L2 interconnect definitions: default bank geometry, arbiter pointer width
// and the packed request payload carried from a master to the memory bank.
package l2_slave_rr_arbiter_pkg;

    localparam int L2_N_MASTER   = 4;
    localparam int L2_PTR_WIDTH  = $clog2(L2_N_MASTER);
    localparam int L2_ID_WIDTH   = L2_N_MASTER;
    localparam int L2_ADDR_WIDTH = 16;
    localparam int L2_DATA_WIDTH = 64;
    localparam int L2_BE_WIDTH   = L2_DATA_WIDTH / 8;

    typedef struct packed {
        logic [L2_ADDR_WIDTH-1:0] add;
        logic                     wen;
        logic [L2_DATA_WIDTH-1:0] wdata;
        logic [L2_BE_WIDTH-1:0]   be;
        logic [L2_ID_WIDTH-1:0]   id;
    } l2_req_t;

endpackage

// File: rtl/l2_slave_rr_arbiter_prio_select.sv
// Combinational round-robin search: first requester at or after ptr, wrapping to 0.
module rr_prio_select_l2
    import l2_slave_rr_arbiter_pkg::*;
#(
    parameter int N_MASTER  = L2_N_MASTER,
    parameter int PTR_WIDTH = L2_PTR_WIDTH
) (
    input  logic [N_MASTER-1:0]  req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [PTR_WIDTH-1:0] winner,
    output logic                 any_valid
);

    // Lowest requester overall covers the wrap; a requester at or above ptr overrides it.
    always_comb begin
        winner    = '0;
        any_valid = |req;
        for (int i = N_MASTER - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = PTR_WIDTH'(i);
            end
        end
        for (int i = N_MASTER - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                winner = PTR_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/l2_slave_rr_arbiter.sv
// Round-robin arbiter in front of one L2 memory bank; routes the one-cycle
// read/write response back to the granted master by its one-hot ID.
module l2_slave_rr_arbiter
    import l2_slave_rr_arbiter_pkg::*;
#(
    parameter int N_MASTER   = L2_N_MASTER,
    parameter int ID_WIDTH   = N_MASTER,
    parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
    parameter int DATA_WIDTH = L2_DATA_WIDTH,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_MASTER-1:0]                  data_req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
    input  logic [N_MASTER-1:0]                  data_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
    input  logic [N_MASTER-1:0][ID_WIDTH-1:0]    data_ID_i,
    output logic [N_MASTER-1:0]                  data_gnt_o,
    output logic                                 data_req_o,
    output logic [ADDR_WIDTH-1:0]                data_add_o,
    output logic                                 data_wen_o,
    output logic [DATA_WIDTH-1:0]                data_wdata_o,
    output logic [BE_WIDTH-1:0]                  data_be_o,
    output logic [ID_WIDTH-1:0]                  data_ID_o,
    input  logic                                 data_gnt_i,
    input  logic [DATA_WIDTH-1:0]                data_r_rdata_i,
    output logic [N_MASTER-1:0]                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
    output logic [ID_WIDTH-1:0]                  data_r_ID_o
);

    logic [L2_PTR_WIDTH-1:0] rr_ptr;
    logic [L2_PTR_WIDTH-1:0] winner;
    logic                    any_req;
    logic                    handshake;
    logic                    r_pending;
    logic [ID_WIDTH-1:0]     r_ID;
    l2_req_t                 sel;

    rr_prio_select_l2 #(
        .N_MASTER  (N_MASTER),
        .PTR_WIDTH (L2_PTR_WIDTH)
    ) u_prio (
        .req       (data_req_i),
        .ptr       (rr_ptr),
        .winner    (winner),
        .any_valid (any_req)
    );

    assign data_req_o = any_req;
    assign handshake  = any_req & data_gnt_i;

    always_comb begin
        sel = '0;
        if (any_req) begin
            sel.add   = data_add_i[winner];
            sel.wen   = data_wen_i[winner];
            sel.wdata = data_wdata_i[winner];
            sel.be    = data_be_i[winner];
            sel.id    = data_ID_i[winner];
        end
    end

    always_comb begin
        data_gnt_o = '0;
        if (any_req) begin
            data_gnt_o[winner] = data_gnt_i;
        end
    end

    assign data_add_o   = sel.add;
    assign data_wen_o   = sel.wen;
    assign data_wdata_o = sel.wdata;
    assign data_be_o    = sel.be;
    assign data_ID_o    = sel.id;

    // Pointer only moves on a handshake so a stalled winner keeps its turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            r_pending <= 1'b0;
            r_ID      <= '0;
        end else begin
            r_pending <= handshake;
            if (handshake) begin
                rr_ptr <= (winner == L2_PTR_WIDTH'(N_MASTER - 1)) ? '0 : winner + 1'b1;
                r_ID   <= sel.id;
            end
        end
    end

    assign data_r_valid_o = {N_MASTER{r_pending}} & r_ID;
    assign data_r_ID_o    = r_ID;
    assign data_r_rdata_o = data_r_rdata_i;

endmodule

// File: tb/tb_l2_slave_rr_arbiter.sv
// Directed and randomized checks of the L2 slave round-robin arbiter against
// a cycle-level behavioural model of arbitration and response routing.
module tb_l2_slave_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int IW = 4;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         data_req_i;
    logic [N-1:0][AW-1:0] data_add_i;
    logic [N-1:0]         data_wen_i;
    logic [N-1:0][DW-1:0] data_wdata_i;
    logic [N-1:0][BW-1:0] data_be_i;
    logic [N-1:0][IW-1:0] data_ID_i;
    logic [N-1:0]         data_gnt_o;
    logic                 data_req_o;
    logic [AW-1:0]        data_add_o;
    logic                 data_wen_o;
    logic [DW-1:0]        data_wdata_o;
    logic [BW-1:0]        data_be_o;
    logic [IW-1:0]        data_ID_o;
    logic                 data_gnt_i;
    logic [DW-1:0]        data_r_rdata_i;
    logic [N-1:0]         data_r_valid_o;
    logic [DW-1:0]        data_r_rdata_o;
    logic [IW-1:0]        data_r_ID_o;

    int vectors;
    int miscompares;

    // behavioural model state
    int           ptr_m;
    bit           pend_m;
    logic [IW-1:0] rid_m;

    l2_slave_rr_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_wen_i     (data_wen_i),
        .data_wdata_i   (data_wdata_i),
        .data_be_i      (data_be_i),
        .data_ID_i      (data_ID_i),
        .data_gnt_o     (data_gnt_o),
        .data_req_o     (data_req_o),
        .data_add_o     (data_add_o),
        .data_wen_o     (data_wen_o),
        .data_wdata_o   (data_wdata_o),
        .data_be_o      (data_be_o),
        .data_ID_o      (data_ID_o),
        .data_gnt_i     (data_gnt_i),
        .data_r_rdata_i (data_r_rdata_i),
        .data_r_valid_o (data_r_valid_o),
        .data_r_rdata_o (data_r_rdata_o),
        .data_r_ID_o    (data_r_ID_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_winner(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        data_req_i     = '0;
        data_add_i     = '0;
        data_wen_i     = '0;
        data_wdata_i   = '0;
        data_be_i      = '0;
        data_gnt_i     = 1'b0;
        data_r_rdata_i = '0;
        for (int i = 0; i < N; i++) data_ID_i[i] = IW'(1 << i);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        ptr_m  = 0;
        pend_m = 1'b0;
        rid_m  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (data_r_valid_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_valid: got %b expected 0000", data_r_valid_o);
        end
        vectors++;
        if (data_r_ID_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_rid: got %b expected 0000", data_r_ID_o);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        ptr_m  = 0;
        pend_m = 1'b0;
        rid_m  = '0;
        data_req_i = 4'b1111;
        data_gnt_i = 1'b1;
        #1;
        vectors++;
        if (data_gnt_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b expected 0001", data_gnt_o);
        end
    endtask

    task automatic test_rr_all();
        logic [N-1:0] exp;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp = (c == 0) ? 4'b0000 : N'(1 << ((c - 1) % N));
            vectors++;
            if (data_r_valid_o !== exp) begin
                miscompares++;
                $display("FAIL rr_all_valid[%0d]: got %b expected %b", c, data_r_valid_o, exp);
            end
            data_req_i = 4'b1111;
            data_gnt_i = 1'b1;
            #1;
            exp = N'(1 << (c % N));
            vectors++;
            if (data_gnt_o !== exp) begin
                miscompares++;
                $display("FAIL rr_all_gnt[%0d]: got %b expected %b", c, data_gnt_o, exp);
            end
        end
        @(negedge clk);
        data_req_i = '0;
        vectors++;
        if (data_r_valid_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL rr_all_valid_last: got %b expected 0001", data_r_valid_o);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int i = 0; i < N; i++) data_add_i[i] = AW'(16'h0100 + i);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            data_req_i = 4'b1010;
            data_gnt_i = 1'b0;
            #1;
            vectors++;
            if (data_gnt_o !== 4'b0000 || data_req_o !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_gnt[%0d]: got gnt %b req %b expected 0000 1", c, data_gnt_o, data_req_o);
            end
            vectors++;
            if (data_add_o !== 16'h0101) begin
                miscompares++;
                $display("FAIL stall_add[%0d]: got %h expected 0101", c, data_add_o);
            end
        end
        @(negedge clk);
        data_gnt_i = 1'b1;
        #1;
        vectors++;
        if (data_gnt_o !== 4'b0010) begin
            miscompares++;
            $display("FAIL stall_release_gnt: got %b expected 0010", data_gnt_o);
        end
        @(negedge clk);
        data_req_i = 4'b1111;
        #1;
        vectors++;
        if (data_gnt_o !== 4'b0100) begin
            miscompares++;
            $display("FAIL stall_ptr_next: got %b expected 0100", data_gnt_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_read_response();
        apply_reset();
        @(negedge clk);
        data_req_i    = 4'b0100;
        data_add_i[2] = 16'h0040;
        data_wen_i[2] = 1'b1;
        data_ID_i[2]  = 4'b0100;
        data_gnt_i    = 1'b1;
        #1;
        vectors++;
        if (data_gnt_o !== 4'b0100 || data_add_o !== 16'h0040 || data_wen_o !== 1'b1 || data_ID_o !== 4'b0100) begin
            miscompares++;
            $display("FAIL read_req: got gnt %b add %h wen %b id %b expected 0100 0040 1 0100",
                     data_gnt_o, data_add_o, data_wen_o, data_ID_o);
        end
        @(negedge clk);
        data_req_i     = '0;
        data_r_rdata_i = 64'hDEADBEEF_00000001;
        #1;
        vectors++;
        if (data_r_valid_o !== 4'b0100 || data_r_ID_o !== 4'b0100 || data_r_rdata_o !== 64'hDEADBEEF_00000001) begin
            miscompares++;
            $display("FAIL read_resp: got valid %b id %b data %h expected 0100 0100 deadbeef00000001",
                     data_r_valid_o, data_r_ID_o, data_r_rdata_o);
        end
        @(negedge clk);
        vectors++;
        if (data_r_valid_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL read_resp_once: got %b expected 0000", data_r_valid_o);
        end
        idle_inputs();
    endtask

    task automatic test_reset_after_hs();
        apply_reset();
        @(negedge clk);
        data_req_i = 4'b1111;
        data_gnt_i = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        data_req_i = '0;
        data_gnt_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (data_r_valid_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_hs_suppress: got %b expected 0000", data_r_valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (data_r_valid_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_hs_after: got %b expected 0000", data_r_valid_o);
        end
        data_req_i = 4'b1111;
        data_gnt_i = 1'b1;
        #1;
        vectors++;
        if (data_gnt_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL rst_hs_next_gnt: got %b expected 0001", data_gnt_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_single();
        logic [N-1:0] exp;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp = (c == 0) ? 4'b0000 : 4'b1000;
            vectors++;
            if (data_r_valid_o !== exp) begin
                miscompares++;
                $display("FAIL single_valid[%0d]: got %b expected %b", c, data_r_valid_o, exp);
            end
            data_req_i = (c < 5) ? 4'b1000 : 4'b0000;
            data_gnt_i = 1'b1;
            #1;
            exp = (c < 5) ? 4'b1000 : 4'b0000;
            vectors++;
            if (data_gnt_o !== exp) begin
                miscompares++;
                $display("FAIL single_gnt[%0d]: got %b expected %b", c, data_gnt_o, exp);
            end
        end
        @(negedge clk);
        vectors++;
        if (data_r_valid_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_valid_end: got %b expected 0000", data_r_valid_o);
        end
        idle_inputs();
    endtask

    task automatic test_idle();
        apply_reset();
        @(negedge clk);
        data_req_i = '0;
        data_gnt_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            data_add_i[i]   = AW'($urandom) | 16'h1;
            data_wen_i[i]   = 1'b1;
            data_wdata_i[i] = {$urandom, $urandom} | 64'h1;
            data_be_i[i]    = 8'hFF;
            data_ID_i[i]    = 4'b1111;
        end
        #1;
        vectors++;
        if (data_req_o !== 1'b0 || data_gnt_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_req_gnt: got req %b gnt %b expected 0 0000", data_req_o, data_gnt_o);
        end
        vectors++;
        if (data_add_o !== '0 || data_wen_o !== 1'b0 || data_wdata_o !== '0 || data_be_o !== '0 || data_ID_o !== '0) begin
            miscompares++;
            $display("FAIL idle_payload: got add %h wen %b wdata %h be %h id %b expected all zero",
                     data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o);
        end
        @(negedge clk);
        vectors++;
        if (data_r_valid_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_valid: got %b expected 0000", data_r_valid_o);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int           w;
        int           r;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_valid;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            exp_valid = pend_m ? rid_m : 4'b0000;
            vectors++;
            if (data_r_valid_o !== exp_valid || data_r_ID_o !== rid_m) begin
                miscompares++;
                $display("FAIL rand_resp[%0d]: got valid %b id %b expected %b %b",
                         c, data_r_valid_o, data_r_ID_o, exp_valid, rid_m);
            end
            r = $urandom_range(0, 9);
            data_req_i = (r == 0) ? 4'b0000 : N'($urandom_range(0, 15));
            data_gnt_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                data_add_i[i]   = AW'($urandom);
                data_wen_i[i]   = 1'($urandom);
                data_wdata_i[i] = {$urandom, $urandom};
                data_be_i[i]    = BW'($urandom);
                r = $urandom_range(0, 7);
                if (r < 5)       data_ID_i[i] = IW'(1 << $urandom_range(0, N - 1));
                else if (r == 5) data_ID_i[i] = '0;
                else             data_ID_i[i] = IW'($urandom);
            end
            data_r_rdata_i = {$urandom, $urandom};
            #1;
            w = model_winner(data_req_i, ptr_m);
            exp_gnt = '0;
            if (w >= 0 && data_gnt_i) exp_gnt[w] = 1'b1;
            vectors++;
            if (data_req_o !== (w >= 0) || data_gnt_o !== exp_gnt) begin
                miscompares++;
                $display("FAIL rand_gnt[%0d]: got req %b gnt %b expected %b %b",
                         c, data_req_o, data_gnt_o, (w >= 0), exp_gnt);
            end
            vectors++;
            if (w >= 0) begin
                if (data_add_o !== data_add_i[w] || data_wen_o !== data_wen_i[w] ||
                    data_wdata_o !== data_wdata_i[w] || data_be_o !== data_be_i[w] ||
                    data_ID_o !== data_ID_i[w]) begin
                    miscompares++;
                    $display("FAIL rand_payload[%0d]: got add %h id %b expected add %h id %b (master %0d)",
                             c, data_add_o, data_ID_o, data_add_i[w], data_ID_i[w], w);
                end
            end else if (data_add_o !== '0 || data_wen_o !== 1'b0 || data_wdata_o !== '0 ||
                         data_be_o !== '0 || data_ID_o !== '0) begin
                miscompares++;
                $display("FAIL rand_payload_idle[%0d]: got add %h id %b expected zero", c, data_add_o, data_ID_o);
            end
            vectors++;
            if (data_r_rdata_o !== data_r_rdata_i) begin
                miscompares++;
                $display("FAIL rand_rdata[%0d]: got %h expected %h", c, data_r_rdata_o, data_r_rdata_i);
            end
            if (w >= 0 && data_gnt_i) begin
                ptr_m  = (w + 1) % N;
                pend_m = 1'b1;
                rid_m  = data_ID_i[w];
            end else begin
                pend_m = 1'b0;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ptr_m       = 0;
        pend_m      = 1'b0;
        rid_m       = '0;
        rst_n       = 1'b1;
        idle_inputs();
        test_reset();
        test_rr_all();
        test_stall();
        test_read_response();
        test_reset_after_hs();
        test_single();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2_slave_rr_arbiter.md
L2_SLAVE_RR_ARBITER -- requirements
Module: l2_slave_rr_arbiter

Interface
REQ-001 Parameters SHALL be: N_MASTER 4, number of requesters (>=2); ID_WIDTH N_MASTER, one-hot requester ID width; ADDR_WIDTH 16, bank word address; DATA_WIDTH 64; BE_WIDTH DATA_WIDTH/8.
REQ-002 Ports SHALL be as listed, clock and reset first; reset is asynchronous and active-low:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- data_req_i  in  N_MASTER  request per master.
- data_add_i / data_wen_i / data_wdata_i / data_be_i / data_ID_i  in  N_MASTER x (ADDR_WIDTH / 1 / DATA_WIDTH / BE_WIDTH / ID_WIDTH)  request payload per master; wen=1 is read.
- data_gnt_o  out  N_MASTER  grant per master.
- data_req_o  out  1  request to memory bank.
- data_add_o / data_wen_o / data_wdata_o / data_be_o / data_ID_o  out  ADDR_WIDTH / 1 / DATA_WIDTH / BE_WIDTH / ID_WIDTH  selected payload.
- data_gnt_i  in  1  bank grant.
- data_r_rdata_i  in  DATA_WIDTH  bank read data, valid one cycle after handshake.
- data_r_valid_o  out  N_MASTER  response valid per master.
- data_r_rdata_o  out  DATA_WIDTH  response data, broadcast.
- data_r_ID_o  out  ID_WIDTH  ID of the response owner.

Function
REQ-003 Handshake SHALL occur in a cycle where data_req_o=1 and data_gnt_i=1.
REQ-004 data_req_o SHALL equal OR of data_req_i, combinationally.
REQ-005 Winner SHALL be the first requesting master at or after rr_ptr in ascending index order, wrapping from N_MASTER-1 to 0.
REQ-006 Payload outputs SHALL be the winner's inputs, combinationally; when no request is pending they SHALL be driven 0.
REQ-007 data_gnt_o[w] SHALL equal data_gnt_i for winner w and 0 for all other masters; at most one bit is high.
REQ-008 rr_ptr SHALL update to (w+1) mod N_MASTER on a handshake only; it SHALL hold when data_gnt_i=0 (a stalled winner is not skipped).
REQ-009 On every handshake, reads and writes alike, the block SHALL register r_pending=1 and r_ID=data_ID_i[w]; otherwise r_pending SHALL be 0 next cycle.
REQ-010 data_r_valid_o[i] SHALL equal r_pending AND r_ID[i]; data_r_ID_o SHALL equal r_ID; data_r_rdata_o SHALL pass data_r_rdata_i through; response latency is exactly 1 cycle after the handshake.
REQ-011 Back-to-back handshakes SHALL yield back-to-back responses with no bubble; throughput is 1 request per cycle.
REQ-012 A master that drops data_req_i before being granted SHALL lose its turn without corrupting rr_ptr.
REQ-013 With a single requester, that requester SHALL be granted every cycle that data_gnt_i=1.
REQ-014 data_ID_i values that are not one-hot SHALL be forwarded unchanged; an all-zero ID SHALL produce no data_r_valid_o bit.

Reset
REQ-015 On rst_n=0 the block SHALL asynchronously set rr_ptr=0, r_pending=0 and r_ID=0; all data_r_valid_o bits are 0 during reset.
REQ-016 Reset asserted one cycle after a handshake SHALL suppress that response.
REQ-017 The first arbitration after reset SHALL favour master 0.

Structure
REQ-018 The pointer-width constant $clog2(N_MASTER) and the request-payload packed struct (add, wen, wdata, be, ID) SHALL reside in the shared L2 interconnect package.
REQ-019 The priority search SHALL be one sub-module, rr_prio_select_l2: input request vector and pointer; outputs winner index and any-valid flag; purely combinational.
REQ-020 The top level SHALL hold only the rr_ptr, r_pending and r_ID registers plus the muxes.

Verification
REQ-021 All four masters request continuously with data_gnt_i=1: grants SHALL be 0,1,2,3,0 on consecutive cycles, and data_r_valid_o SHALL follow one cycle later as 0001, 0010, 0100, 1000.
REQ-022 Masters 1 and 3 request with data_gnt_i=0 for 3 cycles, then 1: data_gnt_o SHALL be 0010 only on the first cycle with data_gnt_i=1, and rr_ptr SHALL become 2.
REQ-023 Master 2 reads address 0x0040 with ID 0100 and data_r_rdata_i=0xDEADBEEF_00000001 in the response cycle: data_r_valid_o SHALL be 0100 and data_r_ID_o SHALL be 0100 with that data, for exactly one cycle.
REQ-024 rst_n is pulsed low in the cycle after a handshake: no data_r_valid_o SHALL assert, and the next grant SHALL go to master 0 when all masters request.
REQ-025 Master 3 alone requests 5 cycles with data_gnt_i=1: data_gnt_o SHALL be 1000 for 5 cycles and data_r_valid_o SHALL be 1000 for 5 cycles, delayed by 1.
REQ-026 With no requests: data_req_o SHALL be 0, all payload outputs 0, and data_gnt_o SHALL be 0 even when data_gnt_i=1.
